// File: rtl/load_store_unit_if.sv
// -----------------------------------------------------------------------------
// load_store_unit_if
// Core-side request/response bundle of the load/store unit.
//   req_valid/req_ready : request handshake (accepted when both are high)
//   req_write           : 1 = store, 0 = load
//   req_size            : 00 byte, 01 half, 10 word, 11 illegal
//   req_unsigned        : zero-extend (1) or sign-extend (0) sub-word loads
//   req_addr            : byte address
//   req_wdata           : right-justified store data
//   resp_valid          : one-cycle completion pulse
//   resp_rdata          : load result, 0 for stores and errors
//   resp_error          : qualifies resp_valid, request rejected
// The master modport is the core's view; the slave modport is the unit's view.
// -----------------------------------------------------------------------------
interface load_store_unit_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [1:0]  req_size;
  logic        req_unsigned;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_error;

  modport master (
    output req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    input  req_ready, resp_valid, resp_rdata, resp_error
  );

  modport slave (
    input  req_valid, req_write, req_size, req_unsigned, req_addr, req_wdata,
    output req_ready, resp_valid, resp_rdata, resp_error
  );
endinterface

// File: rtl/load_store_unit.sv
// -----------------------------------------------------------------------------
// load_store_unit
// Multi-cycle initiator for the data memory port. Accepts byte/half/word loads
// and stores from the core, performs read-modify-write for sub-word stores and
// extracts plus sign/zero-extends sub-word loads. Memory is treated as a
// word-addressed, combinational-read, level-write responder.
//
// Ports:
//   clk           : single clock, rising edge
//   reset         : synchronous, active-high
//   core          : load_store_unit_if.slave request/response bundle
//   mem_address   : registered, word-aligned byte address to memory
//   write_data    : registered full word to memory
//   sig_mem_read  : registered memory read enable
//   sig_mem_write : registered memory write enable
//   read_data     : memory read word
//
// Parameter:
//   MEM_BYTES     : data memory size in bytes (range check only)
//
// Build option: define LSU_ALIGN_CHECK_EN to reject misaligned, illegal-size
// and out-of-range requests with resp_error. Without it, resp_error stays 0,
// size 11 behaves as a word and misaligned addresses are truncated.
// -----------------------------------------------------------------------------
module load_store_unit #(
  parameter int unsigned MEM_BYTES = 1024
) (
  input  logic                    clk,
  input  logic                    reset,
  load_store_unit_if.slave        core,
  output logic [31:0]             mem_address,
  output logic [31:0]             write_data,
  output logic                    sig_mem_read,
  output logic                    sig_mem_write,
  input  logic [31:0]             read_data
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    WRITE = 2'd2,
    RESP  = 2'd3
  } state_t;

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;

  if (MEM_BYTES < 32'd4) begin : g_mem_bytes_check
    $error("MEM_BYTES must cover at least one word");
  end

  // Selects the addressed lane of a word and extends it to 32 bits.
  function automatic logic [31:0] extract_load(input logic [31:0] word,
                                               input logic [1:0]  size,
                                               input logic [1:0]  lane,
                                               input logic        is_unsigned);
    logic [7:0]  b;
    logic [15:0] h;
    logic [31:0] r;
    b = word[{lane, 3'b000} +: 8];
    h = word[{lane[1], 4'b0000} +: 16];
    case (size)
      SIZE_BYTE: r = {{24{~is_unsigned & b[7]}}, b};
      SIZE_HALF: r = {{16{~is_unsigned & h[15]}}, h};
      default:   r = word;
    endcase
    return r;
  endfunction

  // Replaces the addressed lane(s) of a word with right-justified store data.
  function automatic logic [31:0] merge_store(input logic [31:0] word,
                                              input logic [15:0] data,
                                              input logic [1:0]  size,
                                              input logic [1:0]  lane);
    logic [31:0] r;
    r = word;
    case (size)
      SIZE_BYTE: r[{lane, 3'b000} +: 8]    = data[7:0];
      SIZE_HALF: r[{lane[1], 4'b0000} +: 16] = data;
      default:   r = word;
    endcase
    return r;
  endfunction

  state_t      state_r;
  state_t      next_state_s;

  logic        write_r;
  logic [1:0]  size_r;
  logic        unsigned_r;
  logic [1:0]  lane_r;
  logic [15:0] wdata_r;
  logic        err_r;

  logic        accept_s;
  logic        req_err_s;
  logic        req_subword_s;

  logic        req_ready_r,     req_ready_nxt_s;
  logic        resp_valid_r,    resp_valid_nxt_s;
  logic        resp_error_r,    resp_error_nxt_s;
  logic [31:0] resp_rdata_r,    resp_rdata_nxt_s;
  logic [31:0] mem_address_r,   mem_address_nxt_s;
  logic [31:0] write_data_r,    write_data_nxt_s;
  logic        sig_mem_read_r,  sig_mem_read_nxt_s;
  logic        sig_mem_write_r, sig_mem_write_nxt_s;

  // req_ready_r is only ever high while idle, so it alone qualifies acceptance.
  assign accept_s      = core.req_valid & req_ready_r;
  assign req_subword_s = (core.req_size == SIZE_BYTE) || (core.req_size == SIZE_HALF);

`ifdef LSU_ALIGN_CHECK_EN
  // Classifies the incoming request as rejected (illegal size, misaligned, out of range).
  always_comb begin
    req_err_s = (core.req_size == 2'b11)
             || ((core.req_size == SIZE_HALF) && core.req_addr[0])
             || ((core.req_size == SIZE_WORD) && (core.req_addr[1:0] != 2'b00))
             || (core.req_addr >= 32'(MEM_BYTES));
  end
`else
  // No request is ever rejected in this build.
  always_comb begin
    req_err_s = 1'b0;
  end
`endif

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_state_s;
    end
  end

  // Next-state logic. A rejected request spends one quiet cycle in READ with
  // both enables held low, so it answers at the same latency as a load.
  always_comb begin
    next_state_s = state_r;
    case (state_r)
      IDLE: begin
        if (!accept_s) begin
          next_state_s = IDLE;
        end else if (!req_err_s && core.req_write && !req_subword_s) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = READ;
        end
      end
      READ: begin
        if (!err_r && write_r) begin
          next_state_s = WRITE;
        end else begin
          next_state_s = RESP;
        end
      end
      WRITE:   next_state_s = RESP;
      RESP:    next_state_s = IDLE;
      default: next_state_s = IDLE;
    endcase
  end

  // Next values of the registered outputs, derived from the upcoming state.
  always_comb begin
    req_ready_nxt_s     = (next_state_s == IDLE);
    resp_valid_nxt_s    = (next_state_s == RESP);
    resp_error_nxt_s    = (next_state_s == RESP) && err_r;
    sig_mem_write_nxt_s = (next_state_s == WRITE);
    sig_mem_read_nxt_s  = accept_s && (next_state_s == READ) && !req_err_s;

    if (accept_s && !req_err_s) begin
      mem_address_nxt_s = {core.req_addr[31:2], 2'b00};
    end else begin
      mem_address_nxt_s = mem_address_r;
    end

    if (accept_s && !req_err_s && core.req_write && !req_subword_s) begin
      write_data_nxt_s = core.req_wdata;
    end else if ((state_r == READ) && (next_state_s == WRITE)) begin
      write_data_nxt_s = merge_store(read_data, wdata_r, size_r, lane_r);
    end else begin
      write_data_nxt_s = write_data_r;
    end

    // Leaving READ straight for RESP without an error can only be a load.
    if ((state_r == READ) && (next_state_s == RESP) && !err_r) begin
      resp_rdata_nxt_s = extract_load(read_data, size_r, lane_r, unsigned_r);
    end else begin
      resp_rdata_nxt_s = 32'h0000_0000;
    end
  end

  // Request fields captured at acceptance; later input changes are ignored.
  always_ff @(posedge clk) begin
    if (reset) begin
      write_r    <= 1'b0;
      size_r     <= 2'b00;
      unsigned_r <= 1'b0;
      lane_r     <= 2'b00;
      wdata_r    <= 16'h0000;
      err_r      <= 1'b0;
    end else if (accept_s) begin
      write_r    <= core.req_write;
      size_r     <= core.req_size;
      unsigned_r <= core.req_unsigned;
      lane_r     <= core.req_addr[1:0];
      wdata_r    <= core.req_wdata[15:0];
      err_r      <= req_err_s;
    end else begin
      write_r    <= write_r;
      size_r     <= size_r;
      unsigned_r <= unsigned_r;
      lane_r     <= lane_r;
      wdata_r    <= wdata_r;
      err_r      <= err_r;
    end
  end

  // Output registers; reset drops the write enable on the same edge.
  always_ff @(posedge clk) begin
    if (reset) begin
      req_ready_r     <= 1'b0;
      resp_valid_r    <= 1'b0;
      resp_error_r    <= 1'b0;
      resp_rdata_r    <= 32'h0000_0000;
      mem_address_r   <= 32'h0000_0000;
      write_data_r    <= 32'h0000_0000;
      sig_mem_read_r  <= 1'b0;
      sig_mem_write_r <= 1'b0;
    end else begin
      req_ready_r     <= req_ready_nxt_s;
      resp_valid_r    <= resp_valid_nxt_s;
      resp_error_r    <= resp_error_nxt_s;
      resp_rdata_r    <= resp_rdata_nxt_s;
      mem_address_r   <= mem_address_nxt_s;
      write_data_r    <= write_data_nxt_s;
      sig_mem_read_r  <= sig_mem_read_nxt_s;
      sig_mem_write_r <= sig_mem_write_nxt_s;
    end
  end

  assign core.req_ready  = req_ready_r;
  assign core.resp_valid = resp_valid_r;
  assign core.resp_error = resp_error_r;
  assign core.resp_rdata = resp_rdata_r;
  assign mem_address     = mem_address_r;
  assign write_data      = write_data_r;
  assign sig_mem_read    = sig_mem_read_r;
  assign sig_mem_write   = sig_mem_write_r;

endmodule

// File: tb/tb_load_store_unit.sv
// -----------------------------------------------------------------------------
// tb_load_store_unit
// Scoreboard bench: each accepted request pushes its expected response (data,
// error flag, arrival cycle) computed from a word-array reference memory; a
// separate monitor pops and compares on every resp_valid pulse.
// -----------------------------------------------------------------------------
module tb_load_store_unit;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          edge_no;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] mem_address;
  logic [31:0] write_data;
  logic [31:0] read_data;
  logic        sig_mem_read;
  logic        sig_mem_write;

  load_store_unit_if bus();

  load_store_unit #(.MEM_BYTES(1024)) dut (
    .clk           (clk),
    .reset         (reset),
    .core          (bus),
    .mem_address   (mem_address),
    .write_data    (write_data),
    .sig_mem_read  (sig_mem_read),
    .sig_mem_write (sig_mem_write),
    .read_data     (read_data)
  );

  always #5 clk = ~clk;

  logic [31:0] mem     [256];
  logic [31:0] ref_mem [256];
  exp_t        exp_q[$];
  int          checks = 0;
  int          failures = 0;
  int          edge_cnt = 0;
  int          wr_count = 0;
  int          rd_count = 0;
  int          resp_count = 0;
  logic [31:0] last_wr_addr = 32'h0;
  logic [31:0] last_wr_data = 32'h0;
  logic [31:0] last_rd_addr = 32'h0;

  function automatic logic [31:0] init_word(input int i);
    logic [31:0] v;
    v = 32'(i) * 32'h9E37_79B1 + 32'h1234_5678;
    return v;
  endfunction

  function automatic logic model_err(input logic [1:0] sz, input logic [31:0] a);
    logic chk;
    chk = 1'b0;
`ifdef LSU_ALIGN_CHECK_EN
    chk = 1'b1;
`endif
    return chk && ((sz == 2'd3) || (sz == 2'd1 && (a % 32'd2) != 0) ||
                   (sz == 2'd2 && (a % 32'd4) != 0) || (a >= 32'd1024));
  endfunction

  function automatic logic [31:0] load_val(input logic [31:0] word, input logic [1:0] sz,
                                           input logic u, input logic [31:0] a);
    logic [31:0] v;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 32'd4);
      v  = (word >> sh) & 32'h0000_00FF;
      if (!u && v >= 32'h80) v = v | 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      sh = 16 * int'((a / 32'd2) % 32'd2);
      v  = (word >> sh) & 32'h0000_FFFF;
      if (!u && v >= 32'h8000) v = v | 32'hFFFF_0000;
    end else begin
      v = word;
    end
    return v;
  endfunction

  function automatic logic [31:0] store_merge(input logic [31:0] old, input logic [31:0] d,
                                              input logic [1:0] sz, input logic [31:0] a);
    logic [31:0] mask;
    int sh;
    if (sz == 2'd0) begin
      sh = 8 * int'(a % 32'd4);
      mask = 32'h0000_00FF << sh;
    end else if (sz == 2'd1) begin
      sh = 16 * int'((a / 32'd2) % 32'd2);
      mask = 32'h0000_FFFF << sh;
    end else begin
      sh = 0;
      mask = 32'hFFFF_FFFF;
    end
    return (old & ~mask) | ((d << sh) & mask);
  endfunction

  // Memory responder: combinational read, write on the edge ending a write cycle.
  assign read_data = mem[mem_address[9:2]];
  initial begin
    for (int i = 0; i < 256; i++) mem[i] = init_word(i);
    forever begin
      @(posedge clk);
      if (sig_mem_write) mem[mem_address[9:2]] = write_data;
    end
  end

  initial forever begin
    @(posedge clk);
    edge_cnt++;
  end

  // Monitor: bus sanity plus scoreboard pop on every response pulse.
  initial forever begin : monitor
    exp_t e;
    @(negedge clk);
    if (sig_mem_write) begin
      wr_count++;
      last_wr_addr = mem_address;
      last_wr_data = write_data;
    end
    if (sig_mem_read) begin
      rd_count++;
      last_rd_addr = mem_address;
    end
    if (sig_mem_read || sig_mem_write) begin
      checks++;
      if ((sig_mem_read && sig_mem_write) || mem_address[1:0] != 2'b00) begin
        failures++;
        $display("FAIL mem_bus: rd=%b wr=%b addr=%h, required exclusive enables and aligned addr",
                 sig_mem_read, sig_mem_write, mem_address);
      end
    end
    if (bus.resp_valid === 1'b1) begin
      resp_count++;
      checks++;
      if (exp_q.size() == 0) begin
        failures++;
        $display("FAIL unexpected_resp: rdata=%h err=%b at edge %0d, required no response",
                 bus.resp_rdata, bus.resp_error, edge_cnt);
      end else begin
        e = exp_q.pop_front();
        if (bus.resp_rdata !== e.rdata || bus.resp_error !== e.err || edge_cnt != e.edge_no) begin
          failures++;
          $display("FAIL resp: got rdata=%h err=%b edge=%0d, required rdata=%h err=%b edge=%0d",
                   bus.resp_rdata, bus.resp_error, edge_cnt, e.rdata, e.err, e.edge_no);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      failures++;
      $display("FAIL %s: got %h, required %h", name, got, want);
    end
  endtask

  // Called at a negedge; returns at the negedge after the acceptance edge.
  task automatic send(input logic w, input logic [1:0] sz, input logic u,
                      input logic [31:0] a, input logic [31:0] d, input bit hold,
                      input bit expect_resp, input bit fixed, input logic [31:0] fixed_rdata,
                      output int acc);
    exp_t e;
    logic err;
    int   guard;
    int   idx;
    int   lat;
    bus.req_write = w; bus.req_size = sz; bus.req_unsigned = u;
    bus.req_addr = a;  bus.req_wdata = d; bus.req_valid = 1'b1;
    guard = 0;
    while (bus.req_ready !== 1'b1 && guard < 30) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 30) begin
      checks++; failures++;
      $display("FAIL accept_timeout: req_ready low for %0d cycles, required acceptance", guard);
      bus.req_valid = 1'b0;
      acc = -1;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = edge_cnt;
    if (!hold) begin
      bus.req_valid = 1'b0;
      bus.req_addr = $urandom(); bus.req_wdata = $urandom();
      bus.req_size = 2'($urandom_range(0, 3)); bus.req_write = 1'($urandom_range(0, 1));
      bus.req_unsigned = 1'($urandom_range(0, 1));
    end
    err = model_err(sz, a);
    idx = int'((a >> 2) % 32'd256);
    lat = (w && sz < 2'd2 && !err) ? 3 : 2;
    if (expect_resp) begin
      if (!err && w) ref_mem[idx] = store_merge(ref_mem[idx], d, sz, a);
      e.rdata   = (!err && !w) ? load_val(ref_mem[idx], sz, u, a) : 32'h0;
      if (fixed) e.rdata = fixed_rdata;
      e.err     = err;
      e.edge_no = acc + lat - 1;
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_idle();
    int guard;
    guard = 0;
    while ((exp_q.size() != 0 || bus.req_ready !== 1'b1) && guard < 40) begin
      @(negedge clk);
      guard++;
    end
    if (guard >= 40) begin
      checks++; failures++;
      $display("FAIL idle_timeout: %0d responses outstanding, required 0", exp_q.size());
    end
  endtask

  initial begin : stimulus
    int acc, acc1, acc2, acc3, wr0, rd0, rsp0;
    logic [31:0] a;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.req_write = 1'b0; bus.req_size = 2'b00;
    bus.req_unsigned = 1'b0; bus.req_addr = 32'h0; bus.req_wdata = 32'h0;
    repeat (3) @(negedge clk);
    check("reset_outputs",
          {31'h0, bus.req_ready | bus.resp_valid | bus.resp_error | sig_mem_read | sig_mem_write}
            | bus.resp_rdata | mem_address | write_data, 32'h0);
    reset = 1'b0;
    @(negedge clk);
    check("ready_after_reset", {31'h0, bus.req_ready}, 32'h1);

    // Word store then word load.
    wr0 = wr_count;
    send(1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0, 32'h0, acc);
    wait_idle();
    check("word_store_pulses", 32'(wr_count - wr0), 32'd1);
    check("word_store_addr", last_wr_addr, 32'h10);
    check("word_store_data", last_wr_data, 32'hDEAD_BEEF);
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b0, 1'b1, 1'b1, 32'hDEAD_BEEF, acc);
    wait_idle();

    // Sub-word store via read-modify-write.
    send(1'b1, 2'd2, 1'b0, 32'h20, 32'h1122_3344, 1'b0, 1'b1, 1'b0, 32'h0, acc);
    wait_idle();
    wr0 = wr_count; rd0 = rd_count;
    send(1'b1, 2'd0, 1'b0, 32'h22, 32'h0000_00AA, 1'b0, 1'b1, 1'b0, 32'h0, acc);
    wait_idle();
    check("rmw_reads", 32'(rd_count - rd0), 32'd1);
    check("rmw_writes", 32'(wr_count - wr0), 32'd1);
    check("rmw_data", last_wr_data, 32'h11AA_3344);

    // Load extension.
    send(1'b1, 2'd2, 1'b0, 32'h30, 32'h80FF_7F01, 1'b0, 1'b1, 1'b0, 32'h0, acc);
    send(1'b0, 2'd0, 1'b0, 32'h33, 32'h0, 1'b0, 1'b1, 1'b1, 32'hFFFF_FF80, acc);
    send(1'b0, 2'd0, 1'b1, 32'h33, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_0080, acc);
    send(1'b0, 2'd1, 1'b0, 32'h30, 32'h0, 1'b0, 1'b1, 1'b1, 32'h0000_7F01, acc);
    wait_idle();

    // Misaligned word load.
    rd0 = rd_count;
`ifdef LSU_ALIGN_CHECK_EN
    send(1'b0, 2'd2, 1'b0, 32'h31, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, acc);
    wait_idle();
    check("misaligned_no_read", 32'(rd_count - rd0), 32'd0);
`else
    send(1'b0, 2'd2, 1'b0, 32'h31, 32'h0, 1'b0, 1'b1, 1'b1, 32'h80FF_7F01, acc);
    wait_idle();
    check("misaligned_read_addr", last_rd_addr, 32'h30);
`endif

    // Reset during the READ cycle of a byte store.
    wr0 = wr_count; rsp0 = resp_count;
    send(1'b1, 2'd0, 1'b0, 32'h44, 32'h0000_0055, 1'b0, 1'b0, 1'b0, 32'h0, acc);
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    check("reset_abort_wr", {31'h0, sig_mem_write}, 32'h0);
    @(negedge clk);
    check("reset_abort_ready", {31'h0, bus.req_ready}, 32'h1);
    repeat (4) @(negedge clk);
    check("reset_abort_no_write", 32'(wr_count - wr0), 32'd0);
    check("reset_abort_no_resp", 32'(resp_count - rsp0), 32'd0);

    // Back-to-back loads with req_valid held high.
    rsp0 = resp_count;
    send(1'b0, 2'd2, 1'b0, 32'h10, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, acc1);
    send(1'b0, 2'd0, 1'b1, 32'h21, 32'h0, 1'b1, 1'b1, 1'b0, 32'h0, acc2);
    send(1'b0, 2'd1, 1'b0, 32'h32, 32'h0, 1'b0, 1'b1, 1'b0, 32'h0, acc3);
    wait_idle();
    check("b2b_spacing_1", 32'(acc2 - acc1), 32'd3);
    check("b2b_spacing_2", 32'(acc3 - acc2), 32'd3);
    check("b2b_resp_count", 32'(resp_count - rsp0), 32'd3);

    // Randomized traffic.
    for (int n = 0; n < 80; n++) begin
      a = ($urandom_range(0, 7) == 0) ? 32'($urandom()) : 32'($urandom_range(0, 1023));
      send(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
           a, 32'($urandom()), 1'b0, 1'b1, 1'b0, 32'h0, acc);
    end
    wait_idle();

    // Final memory image against the reference.
    for (int i = 0; i < 256; i++) begin
      checks++;
      if (mem[i] !== ref_mem[i]) begin
        failures++;
        $display("FAIL mem_image[%0d]: got %h, required %h", i, mem[i], ref_mem[i]);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
